// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR seed, feedback taps and checker state type
package lfsr_pkg;
  localparam logic [15:0] LFSR_SEED = 16'hABCD;
  localparam int TAP_A = 12;
  localparam int TAP_B = 3;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAIL} chk_state_t;
endpackage

// File: rtl/lfsr16_step.sv
// lfsr16_step: one step of the 16-bit XNOR LFSR shared by generator and checker
module lfsr16_step
  import lfsr_pkg::*;
(
  input  logic [15:0] cur,
  output logic [15:0] nxt
);
  logic fb;
  assign fb = ~(cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D]);
  assign nxt = {fb, cur[15:1]};
endmodule

// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: checks an LFSR stream for lock, per-sample errors and counts
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter int DATA_SIZE = 4,
  parameter int LOCK_CNT  = 8,
  parameter int LOSS_CNT  = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 valid,
  input  logic [DATA_SIZE-1:0] data,
  input  logic                 clr,
  output logic                 locked,
  output logic                 lost,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     smp_cnt
);
  localparam int RUN_MAX = LOCK_CNT > LOSS_CNT ? LOCK_CNT : LOSS_CNT;
  localparam int RUN_W = $clog2(RUN_MAX + 1);
  logic [15:0] lfsr, lfsr_nxt;
  logic [RUN_W-1:0] good, bad, good_n, bad_n;
  chk_state_t state, state_n;
  logic match, mis;
  lfsr16_step u_step (.cur(lfsr), .nxt(lfsr_nxt));
  assign match = data == lfsr[DATA_SIZE-1:0];
  assign mis = valid && !match;
  always_comb begin
    state_n = state;
    good_n = good;
    bad_n = bad;
    if (!valid) begin
      state_n = IDLE;
      good_n = '0;
      bad_n = '0;
    end else begin
      case (state)
        IDLE, ACQ: begin
          good_n = !match ? '0 : state == IDLE ? RUN_W'(1) : good == '1 ? good : good + RUN_W'(1);
          bad_n = '0;
          state_n = (match && good_n >= RUN_W'(LOCK_CNT)) ? LOCKED : ACQ;
        end
        LOCKED: begin
          bad_n = match ? '0 : bad == '1 ? bad : bad + RUN_W'(1);
          state_n = bad_n >= RUN_W'(LOSS_CNT) ? FAIL : LOCKED;
        end
        default: state_n = FAIL;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr <= LFSR_SEED;
      state <= IDLE;
      good <= '0;
      bad <= '0;
      locked <= 1'b0;
      lost <= 1'b0;
      err_pulse <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt <= '0;
      smp_cnt <= '0;
    end else begin
      lfsr <= valid ? lfsr_nxt : LFSR_SEED;
      state <= state_n;
      good <= good_n;
      bad <= bad_n;
      locked <= state_n == LOCKED;
      lost <= state_n == FAIL;
      err_pulse <= mis;
      err_sticky <= !clr && (err_sticky || mis);
      err_cnt <= clr ? '0 : (mis && err_cnt != '1) ? err_cnt + CNT_W'(1) : err_cnt;
      smp_cnt <= clr ? '0 : (valid && smp_cnt != '1) ? smp_cnt + CNT_W'(1) : smp_cnt;
    end
  end
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb_lfsr_stream_checker: random and directed stream checks against a behavioural model
module tb_lfsr_stream_checker;
  localparam int DS = 4, LK = 8, LS = 4, CW = 5, N = 4096;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rstn = 0, valid = 0, clr = 0;
  logic [DS-1:0] data = '0;
  logic locked, lost, err_pulse, err_sticky;
  logic [CW-1:0] err_cnt, smp_cnt;
  logic [15:0] seq [N];
  logic [15:0] r;
  int checks = 0, errors = 0, gidx = 0;
  int m_idx = 0, m_err = 0, m_smp = 0, run_g = 0, run_b = 0;
  bit m_locked = 0, m_lost = 0, m_pulse = 0, m_sticky = 0, mt;
  int er, rv;
  logic [DS-1:0] d;

  always #5 clk = ~clk;

  lfsr_stream_checker #(.DATA_SIZE(DS), .LOCK_CNT(LK), .LOSS_CNT(LS), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .valid(valid), .data(data), .clr(clr),
    .locked(locked), .lost(lost), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_cnt(err_cnt), .smp_cnt(smp_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: position in the seed-restarted sequence plus run lengths of matches/mismatches
  always @(posedge clk) begin
    if (!rstn) begin
      m_idx = 0; m_err = 0; m_smp = 0; run_g = 0; run_b = 0;
      m_locked = 0; m_lost = 0; m_pulse = 0; m_sticky = 0;
    end else begin
      mt = 1;
      if (valid) begin
        mt = data == seq[m_idx % N][DS-1:0];
        m_idx++;
        m_pulse = !mt;
        if (!m_locked && !m_lost) begin
          run_g = mt ? run_g + 1 : 0;
          if (run_g >= LK) begin m_locked = 1; run_b = 0; end
        end else if (m_locked) begin
          run_b = mt ? 0 : run_b + 1;
          if (run_b >= LS) begin m_locked = 0; m_lost = 1; end
        end
      end else begin
        m_idx = 0; m_pulse = 0; m_locked = 0; m_lost = 0; run_g = 0; run_b = 0;
      end
      if (clr) begin
        m_err = 0; m_smp = 0; m_sticky = 0;
      end else if (valid) begin
        m_smp = m_smp < CMAX ? m_smp + 1 : CMAX;
        if (!mt) begin
          m_err = m_err < CMAX ? m_err + 1 : CMAX;
          m_sticky = 1;
        end
      end
    end
    #1;
    chk("locked", locked, m_locked);
    chk("lost", lost, m_lost);
    chk("err_pulse", err_pulse, m_pulse);
    chk("err_sticky", err_sticky, m_sticky);
    chk("err_cnt", err_cnt, m_err);
    chk("smp_cnt", smp_cnt, m_smp);
  end

  task automatic step(input logic v, input logic [DS-1:0] dd, input logic c);
    valid = v; data = dd; clr = c;
    @(negedge clk);
  endtask

  task automatic send(input int n, input bit f);
    for (int i = 0; i < n; i++) begin
      step(1'b1, seq[gidx][DS-1:0] ^ DS'(f), 1'b0);
      gidx++;
    end
  endtask

  task automatic gap();
    step(1'b0, '0, 1'b0);
    gidx = 0;
  endtask

  task automatic zero_chk(input string nm);
    chk({nm, "_locked"}, locked, 0);
    chk({nm, "_lost"}, lost, 0);
    chk({nm, "_pulse"}, err_pulse, 0);
    chk({nm, "_sticky"}, err_sticky, 0);
    chk({nm, "_err"}, err_cnt, 0);
    chk({nm, "_smp"}, smp_cnt, 0);
  endtask

  task automatic do_reset();
    rstn = 0; valid = 0; clr = 0;
    #1 zero_chk("rst_mid");
    @(negedge clk);
    rstn = 1;
    gidx = 0;
  endtask

  initial begin
    r = 16'hABCD;
    for (int i = 0; i < N; i++) begin
      seq[i] = r;
      r = {~(r[12] ^ r[3] ^ r[1] ^ r[0]), r[15:1]};
    end
    chk("seq0", 32'(seq[0][3:0]), 32'hD);
    chk("seq1", 32'(seq[1][3:0]), 32'h6);
    chk("seq2", 32'(seq[2][3:0]), 32'h3);
    #2 zero_chk("rst");
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    send(7, 0);
    chk("no_lock_7", locked, 0);
    send(1, 0);
    chk("lock_8", locked, 1);
    send(12, 0);
    send(1, 1);
    chk("flip_pulse", err_pulse, 1);
    chk("flip_err", err_cnt, 1);
    send(9, 0);
    chk("flip_locked", locked, 1);
    chk("flip_sticky", err_sticky, 1);
    chk("smp_30", smp_cnt, 30);
    send(3, 1);
    chk("bad3_locked", locked, 1);
    send(1, 1);
    chk("bad4_lost", lost, 1);
    chk("bad4_unlocked", locked, 0);
    chk("bad4_err", err_cnt, 5);
    chk("smp_sat", smp_cnt, CMAX);
    gap();
    chk("gap_lost", lost, 0);
    chk("gap_err_hold", err_cnt, 5);
    send(8, 0);
    chk("relock", locked, 1);
    gap();
    gidx = 1;
    send(40, 0);
    gap();
    step(1'b1, seq[0][DS-1:0] ^ DS'(1), 1'b1);
    gidx = 1;
    chk("clr_err", err_cnt, 0);
    chk("clr_sticky", err_sticky, 0);
    chk("clr_pulse", err_pulse, 1);
    send(1, 1);
    chk("post_clr_err", err_cnt, 1);
    step(1'b0, '0, 1'b1);
    gidx = 0;
    send(40, 1);
    chk("sat_err", err_cnt, CMAX);
    chk("sat_pulse", err_pulse, 1);
    send(1, 0);
    chk("sat_pulse_lo", err_pulse, 0);
    send(1, 1);
    chk("sat_pulse_hi", err_pulse, 1);
    chk("sat_hold", err_cnt, CMAX);
    send(5, 0);
    do_reset();
    send(8, 0);
    chk("lock_after_rst", locked, 1);
    for (int b = 0; b < 60; b++) begin
      er = (b % 3 == 0) ? 0 : (b % 3 == 1) ? 5 : 40;
      for (int i = 0; i < 50; i++) begin
        rv = $urandom_range(0, 999);
        if (rv < 5) do_reset();
        else if (rv < 40) gap();
        else begin
          d = ($urandom_range(0, 99) < er) ? DS'($urandom) : seq[gidx][DS-1:0];
          step(1'b1, d, $urandom_range(0, 99) < 3);
          gidx++;
        end
      end
    end
    gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Receives the `Valid`/`Data` stream from the LFSR data generator and checks it against a local copy of the generator sequence. It reports acquisition lock, per-sample errors and saturating error/sample counters. It sits directly downstream of the generator, or after any link or FIFO that carries its stream, and provides pass/fail status for bring-up and BER measurement.

## Interface
- `DATA_SIZE`, default 4: stream data width; 1..16; compared against the low bits of the reference LFSR.
- `LOCK_CNT`, default 8: number of consecutive good samples needed to declare lock; ≥1.
- `LOSS_CNT`, default 4: number of consecutive bad samples in LOCKED that declare loss; ≥1.
- `CNT_W`, default 16: width of the error and sample counters.
- `clk`  in  1  clock.
- `rstn`  in  1  reset; asynchronous, active-low.
- `valid`  in  1  stream qualifier.
- `data`  in  DATA_SIZE  stream sample; compared only when `valid`=1.
- `clr`  in  1  synchronous clear of counters and the sticky flag; does not affect the FSM or the reference LFSR.
- `locked`  out  1  high while the FSM is in LOCKED.
- `lost`  out  1  high while the FSM is in FAIL.
- `err_pulse`  out  1  one-cycle pulse per mismatched sample.
- `err_sticky`  out  1  set by any mismatch; cleared by `clr` or reset.
- `err_cnt`  out  CNT_W  mismatch count; saturates at all-ones.
- `smp_cnt`  out  CNT_W  count of compared samples; saturates at all-ones.

## Operation
- Reference LFSR `ref[15:0]`:
  - Reset value 16'hABCD.
  - While `valid`=0: `ref` is reloaded with 16'hABCD.
  - While `valid`=1: `ref` steps to `{fb, ref[15:1]}`, where `fb = ~(ref[12]^ref[3]^ref[1]^ref[0])`.
- Expected sample = `ref[DATA_SIZE-1:0]`, taken before the step. The first valid sample after any `valid` low period therefore expects the seed's low bits (0xD for DATA_SIZE=4).
- `match = (data == ref[DATA_SIZE-1:0])`, evaluated only when `valid`=1.
- FSM states: IDLE, ACQ, LOCKED, FAIL.
  - IDLE: entered at reset and from any state when `valid`=0. On a valid sample, go to ACQ and start the good-run count (1 on match, 0 on mismatch).
  - ACQ: a match increments the good-run count. At LOCK_CNT consecutive matches, go to LOCKED. A mismatch resets the good-run count to 0.
  - LOCKED: a mismatch increments the bad-run count and a match clears it. At LOSS_CNT consecutive mismatches, go to FAIL.
  - FAIL: stays until `valid`=0, then goes to IDLE. There is no in-band resync, because the generator restarts from the seed only after `valid` deasserts.
- Error accounting:
  - Every mismatch, in any state, pulses `err_pulse`, sets `err_sticky` and increments `err_cnt`.
  - Every valid sample increments `smp_cnt`.
- `clr` together with a sample on the same cycle: `clr` wins. Counters go to 0 and the sticky flag to 0, and that sample is not counted. FSM and `ref` still advance normally.
- Run counters are sized `$clog2(max(LOCK_CNT,LOSS_CNT)+1)` and saturate; they never wrap.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Latency: a sample presented in cycle t is reflected in `err_pulse`, `err_cnt`, `smp_cnt` and the FSM outputs in cycle t+1.
- `locked` rises in the cycle after the LOCK_CNT-th consecutive good sample.
- `lost` rises in the cycle after the LOSS_CNT-th consecutive bad sample in LOCKED.
- Deasserting `valid` for one cycle:
  - `locked` and `lost` drop in the next cycle.
  - `ref` is reseeded.
  - Counters hold.
- Asserting `rstn` mid-stream clears everything immediately. After release, the checker behaves exactly like the generator restarting from its seed.
- Saturation: once `err_cnt` is all-ones it holds at all-ones, and `err_pulse` still fires on further mismatches.

## Structure
- Shared package `lfsr_pkg`:
  - `LFSR_SEED` = 16'hABCD.
  - Tap constants 12/3/1/0.
  - State enum `chk_state_t` {IDLE, ACQ, LOCKED, FAIL}.
- One sub-module, `lfsr16_step`: combinational next-state and feedback. It is reused by the generator so the polynomial is defined in one place.

## Test plan
- Generator-accurate stream after reset: `valid` high, data D,6,3,… following the LFSR from seed ABCD → `locked`=1 at the cycle after sample 8; `err_cnt`=0; `smp_cnt`=N.
- Single bit flip in LOCKED (sample 20 XOR 1) → one `err_pulse` at cycle +1; `err_cnt`=1; `err_sticky`=1; `locked` stays 1.
- Four consecutive corrupted samples in LOCKED → `lost`=1 and `locked`=0 after the 4th; `err_cnt`=4. Then `valid` low for 1 cycle and a clean stream → IDLE, then ACQ, then LOCKED after 8 samples.
- Stream started one sample late (first valid data 6 instead of D) → never locks; `err_cnt` increments on nearly every sample; `locked` stays 0.
- `clr` in the same cycle as a mismatching sample → `err_cnt`=0, `err_sticky`=0 next cycle; a subsequent mismatch gives `err_cnt`=1.
- Preload `err_cnt` to all-ones (CNT_W=4, 16 errors) → `err_cnt` holds at 15 and `err_pulse` still toggles. Asserting `rstn` mid-run → all outputs 0 immediately and `ref` = ABCD.
